// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 16-bit main memory between I-cache fills, D-cache fills
// and D-cache write-through; issues block-fill bursts and drives the pipeline stalls.
module mem_arbiter #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4,
  localparam int WIDX           = $clog2(WORDS_PER_BLOCK)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ic_miss,
  input  logic [15:0]     ic_miss_addr,
  input  logic            dc_miss,
  input  logic [15:0]     dc_miss_addr,
  input  logic            dc_wr_req,
  input  logic [15:0]     dc_wr_addr,
  input  logic [15:0]     dc_wr_data,
  output logic            mem_en,
  output logic            mem_wr,
  output logic [15:0]     mem_addr,
  output logic [15:0]     mem_wdata,
  input  logic [15:0]     mem_rdata,
  input  logic            mem_data_valid,
  output logic [15:0]     fill_data,
  output logic [WIDX-1:0] fill_word,
  output logic            ic_fill_we,
  output logic            dc_fill_we,
  output logic            ic_fill_done,
  output logic            dc_fill_done,
  output logic            dc_wr_ack,
  output logic            stall_fetch,
  output logic            stall_mem
);

  if ((WORDS_PER_BLOCK < 2) || ((WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) ||
      (MEM_LATENCY < 1)) begin : g_bad_param
    $error("mem_arbiter: WORDS_PER_BLOCK must be a power of two >= 2, MEM_LATENCY >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_IC_FILL = 2'd2,
    ST_DC_FILL = 2'd3
  } state_t;

  // Clears the word offset and the byte-within-word bit of a miss address.
  localparam logic [15:0]     BASE_MASK = ~16'((2 * WORDS_PER_BLOCK) - 1);
  localparam logic [WIDX:0]   ISS_ONE   = (WIDX + 1)'(1'b1);
  localparam logic [WIDX-1:0] RET_ONE   = WIDX'(1'b1);
  localparam logic [WIDX-1:0] RET_LAST  = '1;

  state_t          state_r, state_nxt_s;
  logic [15:0]     base_r, base_nxt_s;
  logic [WIDX:0]   iss_cnt_r, iss_cnt_nxt_s;
  logic [WIDX-1:0] ret_cnt_r, ret_cnt_nxt_s;
  logic            last_dc_r, last_dc_nxt_s;
  logic [15:0]     iss_off_s;
  logic            fill_dc_s;

  assign fill_dc_s = (state_r == ST_DC_FILL);
  assign fill_word = ret_cnt_r;

  // Byte offset of the current issue: word index times two.
  always_comb begin
    iss_off_s         = 16'h0000;
    iss_off_s[WIDX:1] = iss_cnt_r[WIDX-1:0];
  end

  // Next-state, counter updates and memory/fill outputs.
  always_comb begin
    state_nxt_s   = state_r;
    base_nxt_s    = base_r;
    iss_cnt_nxt_s = iss_cnt_r;
    ret_cnt_nxt_s = ret_cnt_r;
    last_dc_nxt_s = last_dc_r;
    mem_en        = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = 16'h0000;
    mem_wdata     = 16'h0000;
    fill_data     = 16'h0000;
    ic_fill_we    = 1'b0;
    dc_fill_we    = 1'b0;
    ic_fill_done  = 1'b0;
    dc_fill_done  = 1'b0;
    dc_wr_ack     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        iss_cnt_nxt_s = '0;
        ret_cnt_nxt_s = '0;
        // Write-through wins; two misses alternate against the previous grant.
        if (dc_wr_req) begin
          state_nxt_s = ST_WRITE;
        end else if (dc_miss && (!ic_miss || !last_dc_r)) begin
          state_nxt_s = ST_DC_FILL;
          base_nxt_s  = dc_miss_addr & BASE_MASK;
        end else if (ic_miss) begin
          state_nxt_s = ST_IC_FILL;
          base_nxt_s  = ic_miss_addr & BASE_MASK;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        mem_en      = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = dc_wr_addr;
        mem_wdata   = dc_wr_data;
        dc_wr_ack   = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      ST_IC_FILL, ST_DC_FILL: begin
        // Issue MSB set means every word of the block has been requested.
        if (!iss_cnt_r[WIDX]) begin
          mem_en        = 1'b1;
          mem_addr      = base_r + iss_off_s;
          iss_cnt_nxt_s = iss_cnt_r + ISS_ONE;
        end else begin
          iss_cnt_nxt_s = iss_cnt_r;
        end
        if (mem_data_valid) begin
          fill_data     = mem_rdata;
          ic_fill_we    = !fill_dc_s;
          dc_fill_we    = fill_dc_s;
          ret_cnt_nxt_s = ret_cnt_r + RET_ONE;
          if (ret_cnt_r == RET_LAST) begin
            ic_fill_done  = !fill_dc_s;
            dc_fill_done  = fill_dc_s;
            last_dc_nxt_s = fill_dc_s;
            state_nxt_s   = ST_IDLE;
          end else begin
            state_nxt_s = state_r;
          end
        end else begin
          ret_cnt_nxt_s = ret_cnt_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      base_r    <= 16'h0000;
      iss_cnt_r <= '0;
      ret_cnt_r <= '0;
      last_dc_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      base_r    <= base_nxt_s;
      iss_cnt_r <= iss_cnt_nxt_s;
      ret_cnt_r <= ret_cnt_nxt_s;
      last_dc_r <= last_dc_nxt_s;
    end
  end

  assign stall_mem   = dc_miss | (dc_wr_req & ~dc_wr_ack);
  assign stall_fetch = ic_miss | stall_mem;

endmodule
